// File: rtl/sc_lfsr_pkg.sv
// Shared definitions for the stochastic bitstream generator: supported LFSR widths,
// maximal-length tap masks and the frame FSM state encoding.
package sc_lfsr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sc_state_e;

    localparam int MAX_WIDTH            = 16;
    localparam int NUM_SUPPORTED_WIDTHS = 9;
    localparam int SUPPORTED_WIDTHS [NUM_SUPPORTED_WIDTHS] = '{3, 4, 5, 6, 7, 8, 10, 12, 16};

    // Each mask selects the feedback taps of a maximal-length polynomial, so a
    // non-zero state cycles through all 2^n-1 non-zero values before repeating.
    function automatic logic [MAX_WIDTH-1:0] lfsr_tap_mask(input int n);
        case (n)
            3:       lfsr_tap_mask = 16'h0006;
            4:       lfsr_tap_mask = 16'h000C;
            5:       lfsr_tap_mask = 16'h0014;
            6:       lfsr_tap_mask = 16'h0030;
            7:       lfsr_tap_mask = 16'h0060;
            8:       lfsr_tap_mask = 16'h00B8;
            10:      lfsr_tap_mask = 16'h0240;
            12:      lfsr_tap_mask = 16'h0829;
            16:      lfsr_tap_mask = 16'hB400;
            default: lfsr_tap_mask = 16'h0000;
        endcase
    endfunction

    function automatic bit width_supported(input int n);
        width_supported = 1'b0;
        for (int i = 0; i < NUM_SUPPORTED_WIDTHS; i++) begin
            if (SUPPORTED_WIDTHS[i] == n) width_supported = 1'b1;
        end
    endfunction

endpackage

// File: rtl/sc_lfsr_core.sv
// One Fibonacci LFSR channel: loads a seed (zero replaced by all-ones so the
// register can never lock up) and advances one step per enabled cycle.
module sc_lfsr_core
    import sc_lfsr_pkg::*;
#(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         step,
    output logic [N-1:0] state
);

    localparam logic [MAX_WIDTH-1:0] TAP_FULL = lfsr_tap_mask(N);
    localparam logic [N-1:0]         TAP      = TAP_FULL[N-1:0];

    logic [N-1:0] state_q;
    logic [N-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? '1 : load_val;
        end else if (step) begin
            state_d = {state_q[N-2:0], ^(state_q & TAP)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sc_bitstream_gen_mc.sv
// Multi-channel stochastic bitstream generator: one exact-length frame of
// 2^N-1 beats per start, each channel emitting exactly k_c ones per frame.
module sc_bitstream_gen_mc
    import sc_lfsr_pkg::*;
#(
    parameter int N  = 7,
    parameter int CH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            corr_mode,
    input  logic [CH*N-1:0] k,
    input  logic [CH*N-1:0] seed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH-1:0]   x_out,
    output logic            out_last,
    output logic [N-1:0]    bit_idx,
    output logic            busy,
    output logic            done,
    output logic [CH*N-1:0] lfsr_val
);

    if (!width_supported(N)) begin : g_bad_width
        $error("sc_bitstream_gen_mc: unsupported N=%0d", N);
    end
    if (CH < 1 || CH > 16) begin : g_bad_ch
        $error("sc_bitstream_gen_mc: unsupported CH=%0d", CH);
    end

    // Final beat index 2^N-2: all ones except bit 0.
    localparam logic [N-1:0] LAST_IDX = {{(N-1){1'b1}}, 1'b0};

    sc_state_e       state_q, state_d;
    logic [N-1:0]    bit_idx_q, bit_idx_d;
    logic [CH*N-1:0] k_q, k_d;
    logic            corr_q, corr_d;
    logic            done_q, done_d;
    logic            lfsr_load;
    logic            lfsr_step;
    logic            run;
    logic [N-1:0]    lfsr_state [CH];

    // Handshake: a beat transfers when out_valid && out_ready; out_valid is a
    // pure decode of the state register, so out_ready never feeds back into it.
    // abort wins over a coincident beat, which is then discarded.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        k_d       = k_q;
        corr_d    = corr_q;
        done_d    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    k_d       = k;
                    corr_d    = corr_mode;
                    bit_idx_d = '0;
                    lfsr_load = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    lfsr_step = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            k_q       <= '0;
            corr_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            k_q       <= k_d;
            corr_q    <= corr_d;
            done_q    <= done_d;
        end
    end

    assign run       = (state_q == RUN);
    assign busy      = run;
    assign out_valid = run;
    assign out_last  = run && (bit_idx_q == LAST_IDX);
    assign bit_idx   = bit_idx_q;
    assign done      = done_q;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic         ch_step;
        logic [N-1:0] sel_lfsr;

        // In correlated mode only LFSR 0 drives the comparators, so the rest hold.
        assign ch_step = lfsr_step && ((c == 0) || !corr_q);

        sc_lfsr_core #(.N(N)) u_lfsr (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (lfsr_load),
            .load_val (seed[c*N +: N]),
            .step     (ch_step),
            .state    (lfsr_state[c])
        );

        assign sel_lfsr            = corr_q ? lfsr_state[0] : lfsr_state[c];
        assign x_out[c]            = run && (sel_lfsr <= k_q[c*N +: N]);
        assign lfsr_val[c*N +: N]  = lfsr_state[c];
    end

endmodule

// File: tb/tb_sc_bitstream_gen_mc.sv
// Directed bench for sc_bitstream_gen_mc: frame length, exact ones counts,
// correlation, backpressure, zero seed, abort, reset mid-frame, back-to-back.
module tb_sc_bitstream_gen_mc;

    localparam int N  = 7;
    localparam int CH = 4;
    localparam int W  = N * CH;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=7 instance
    logic          start, abort, corr_mode, out_ready;
    logic [W-1:0]  k, seed;
    logic          out_valid, out_last, busy, done;
    logic [CH-1:0] x_out;
    logic [N-1:0]  bit_idx;
    logic [W-1:0]  lfsr_val;

    // N=3 instance
    logic          start3, abort3, corr3, ready3;
    logic [5:0]    k3, seed3;
    logic          valid3, last3, busy3, done3;
    logic [1:0]    x3;
    logic [2:0]    idx3;
    logic [5:0]    lfsr3;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    sc_bitstream_gen_mc #(.N(N), .CH(CH)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .corr_mode(corr_mode),
        .k(k), .seed(seed), .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
        .out_last(out_last), .bit_idx(bit_idx), .busy(busy), .done(done), .lfsr_val(lfsr_val)
    );

    sc_bitstream_gen_mc #(.N(3), .CH(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .corr_mode(corr3),
        .k(k3), .seed(seed3), .out_valid(valid3), .out_ready(ready3), .x_out(x3),
        .out_last(last3), .bit_idx(idx3), .busy(busy3), .done(done3), .lfsr_val(lfsr3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a frame in the current cycle and runs it to the done cycle; returns
    // at the negedge of the done cycle so a caller may start back-to-back.
    task automatic run_frame(input logic [W-1:0] kv, input logic [W-1:0] sv,
                             input logic mode, input int ready_pct,
                             input bit check_imp, input string tag);
        int ones [CH];
        int beats = 0, cyc = 0, last_cnt = 0;
        int idx_err = 0, last_err = 0, done_err = 0, stall_err = 0;
        int per_err = 0, imp_err = 0, valid_err = 0;
        bit seen [128];
        logic [W-1:0]  exp_seed;
        logic          stalled = 1'b0;
        logic [CH-1:0] px;
        logic [N-1:0]  pidx;
        logic [W-1:0]  plfsr;
        logic [N-1:0]  v;

        for (int c = 0; c < CH; c++) begin
            ones[c] = 0;
            exp_seed[c*N +: N] = (sv[c*N +: N] == '0) ? 7'h7F : sv[c*N +: N];
            exp_q.push_back(int'(kv[c*N +: N]));
        end
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;

        start = 1'b1; k = kv; seed = sv; corr_mode = mode; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        check({tag, " first_lfsr"}, 64'(lfsr_val), 64'(exp_seed));

        while (beats < 127 && cyc < 4000) begin
            if (out_valid !== 1'b1) valid_err++;
            if (done !== 1'b0) done_err++;
            if (stalled && (x_out !== px || bit_idx !== pidx || lfsr_val !== plfsr)) stall_err++;
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && out_ready) begin
                for (int c = 0; c < CH; c++) ones[c] += int'(x_out[c]);
                if (bit_idx !== 7'(beats)) idx_err++;
                if (out_last !== (beats == 126)) last_err++;
                if (out_last === 1'b1) last_cnt++;
                v = lfsr_val[N-1:0];
                if (v == '0 || seen[v]) per_err++;
                seen[v] = 1'b1;
                for (int c = 0; c < CH - 1; c++) begin
                    if (x_out[c] && !x_out[c+1]) imp_err++;
                end
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
            end
            px = x_out; pidx = bit_idx; plfsr = lfsr_val;
            @(negedge clk);
            cyc++;
        end

        check({tag, " beats"}, 64'(beats), 64'd127);
        if (ready_pct >= 100) check({tag, " valid_cycles"}, 64'(cyc), 64'd127);
        check({tag, " valid_in_run"}, 64'(valid_err), 64'd0);
        check({tag, " bit_idx_seq"}, 64'(idx_err), 64'd0);
        check({tag, " out_last_pos"}, 64'(last_err), 64'd0);
        check({tag, " out_last_cnt"}, 64'(last_cnt), 64'd1);
        check({tag, " no_early_done"}, 64'(done_err), 64'd0);
        check({tag, " stall_stable"}, 64'(stall_err), 64'd0);
        check({tag, " lfsr_period"}, 64'(per_err), 64'd0);
        if (check_imp) check({tag, " corr_implication"}, 64'(imp_err), 64'd0);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s ones_ch%0d", tag, c), 64'(ones[c]), 64'(exp_q.pop_front()));
        end
        check({tag, " done_pulse"}, 64'(done), 64'd1);
        check({tag, " idle_busy"}, 64'(busy), 64'd0);
        check({tag, " idle_valid"}, 64'(out_valid), 64'd0);
        check({tag, " idle_x_out"}, 64'(x_out), 64'd0);
        check({tag, " lfsr_wrapped"}, 64'(lfsr_val), 64'(exp_seed));
    endtask

    initial begin
        logic [W-1:0] lfsr_snap;
        int ones3 [2];
        int beats3;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; corr_mode = 1'b0; out_ready = 1'b0;
        k = '0; seed = '0;
        start3 = 1'b0; abort3 = 1'b0; corr3 = 1'b0; ready3 = 1'b0; k3 = '0; seed3 = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_last", 64'(out_last), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst x_out", 64'(x_out), 64'd0);
        check("rst bit_idx", 64'(bit_idx), 64'd0);
        check("rst lfsr_val", 64'(lfsr_val), 64'h0FFF_FFFF);
        check("rst lfsr3", 64'(lfsr3), 64'h3F);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame({7'd127, 7'd64, 7'd1, 7'd0}, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b0, 100, 1'b0, "indep");
        run_frame({7'd127, 7'd80, 7'd40, 7'd10}, {7'd33, 7'd17, 7'd9, 7'd5}, 1'b1, 100, 1'b1, "corr");
        run_frame({7'd127, 7'd64, 7'd1, 7'd0}, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b0, 50, 1'b0, "bp");
        run_frame({7'd127, 7'd127, 7'd127, 7'd127}, '0, 1'b0, 100, 1'b0, "zseed");

        // N=3 variant: zero seeds, k = {3, 7}
        start3 = 1'b1; k3 = {3'd3, 3'd7}; seed3 = '0; ready3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("n3 first_lfsr", 64'(lfsr3), 64'h3F);
        ones3[0] = 0; ones3[1] = 0; beats3 = 0;
        for (int i = 0; i < 50 && busy3; i++) begin
            if (valid3) begin
                ones3[0] += int'(x3[0]);
                ones3[1] += int'(x3[1]);
                beats3++;
            end
            @(negedge clk);
        end
        check("n3 beats", 64'(beats3), 64'd7);
        check("n3 ones_ch0", 64'(ones3[0]), 64'd7);
        check("n3 ones_ch1", 64'(ones3[1]), 64'd3);
        check("n3 done", 64'(done3), 64'd1);
        ready3 = 1'b0;

        // Abort: hand-stepped LFSR values first, then abort at bit_idx 50
        start = 1'b1; corr_mode = 1'b0; out_ready = 1'b1;
        k = {7'd0, 7'd0, 7'h40, 7'h5F}; seed = {7'd3, 7'd3, 7'h40, 7'h60};
        @(negedge clk);
        start = 1'b0;
        check("abort first_lfsr", 64'(lfsr_val[13:0]), 64'({7'h40, 7'h60}));
        check("abort first_x", 64'(x_out), 64'b0010);
        @(negedge clk);
        check("abort step_lfsr", 64'(lfsr_val[13:0]), 64'({7'h01, 7'h40}));
        check("abort step_x", 64'(x_out), 64'b0011);
        for (int i = 0; i < 300 && bit_idx != 7'd50; i++) @(negedge clk);
        check("abort reach_idx50", 64'(bit_idx), 64'd50);
        lfsr_snap = lfsr_val;
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort valid", 64'(out_valid), 64'd0);
        check("abort no_done", 64'(done), 64'd0);
        check("abort idx_held", 64'(bit_idx), 64'd50);
        check("abort lfsr_held", 64'(lfsr_val), 64'(lfsr_snap));
        @(negedge clk);
        check("abort start_ignored", 64'(busy), 64'd0);
        check("abort no_done2", 64'(done), 64'd0);
        run_frame({7'd127, 7'd64, 7'd1, 7'd0}, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b0, 100, 1'b0, "restart");

        // Reset mid-frame at bit_idx 30
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1; k = {4{7'd64}}; seed = {7'd9, 7'd7, 7'd5, 7'd3};
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300 && bit_idx != 7'd30; i++) @(negedge clk);
        check("mrst reach_idx30", 64'(bit_idx), 64'd30);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst busy", 64'(busy), 64'd0);
        check("mrst out_valid", 64'(out_valid), 64'd0);
        check("mrst out_last", 64'(out_last), 64'd0);
        check("mrst x_out", 64'(x_out), 64'd0);
        check("mrst bit_idx", 64'(bit_idx), 64'd0);
        check("mrst lfsr_val", 64'(lfsr_val), 64'h0FFF_FFFF);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst no_done", 64'(done), 64'd0);

        run_frame({7'd100, 7'd20, 7'd126, 7'd1}, {7'd11, 7'd0, 7'd77, 7'd126}, 1'b0, 100, 1'b0, "b2b_a");
        check("b2b done_at_start", 64'(done), 64'd1);
        run_frame({7'd3, 7'd60, 7'd90, 7'd127}, {7'd1, 7'd2, 7'd3, 7'd4}, 1'b0, 100, 1'b0, "b2b_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_bitstream_gen_mc.md
# sc_bitstream_gen_mc

Multi-channel, frame-controlled stochastic bitstream generator for the decompressor datapath. It generates one exact-length frame per start request. Each of CH channels encodes an N-bit value k as a unary-density bitstream of 2^N−1 bits, using either an independent LFSR per channel or one LFSR shared by all channels (correlated mode). The output uses a valid/ready stream so downstream stochastic arithmetic can apply backpressure.

## Interface
- N, 7: value/LFSR width. Supported values are 3, 4, 5, 6, 7, 8, 10, 12, 16; any other value is an elaboration error.
- CH, 4: number of channels, 1..16.
- clk  in  1  clock. All logic is rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- abort  in  1  terminate the current frame; honoured only in RUN.
- corr_mode  in  1  0 = independent LFSR per channel, 1 = all channels use LFSR 0. Latched at start.
- k  in  CH*N  packed per-channel values; channel c is k[c*N +: N]. Latched at start.
- seed  in  CH*N  packed per-channel seeds. Latched at start.
- out_valid  out  1  x_out is valid.
- out_ready  in  1  downstream accepts the current bit.
- x_out  out  CH  per-channel stochastic bit.
- out_last  out  1  current beat is the final bit of the frame.
- bit_idx  out  N  index of the current beat, 0..2^N−2.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after a frame completes normally.
- lfsr_val  out  CH*N  current LFSR states, for debug.

## Operation
- States are IDLE and RUN.
- **IDLE.** If start is high:
  - Latch k and corr_mode.
  - Load each LFSR c with seed_c. A zero seed is replaced by all-ones.
  - Clear bit_idx and go to RUN.
- **RUN.**
  - out_valid = 1.
  - x_out[c] = (L_c <= k_c), where L_c is LFSR c when corr_mode = 0 and LFSR 0 when corr_mode = 1.
  - Comparison is unsigned, N bits.
- **Exact-density property.** The LFSR visits every value 1..2^N−1 exactly once per frame. Each channel therefore emits exactly k_c ones in 2^N−1 bits. k = 0 gives all zeros; k = 2^N−1 gives all ones.
- **Beat handshake.** A beat fires when out_valid && out_ready. On a beat, every LFSR advances one step and bit_idx increments.
  - In correlated mode only LFSR 0 has to advance; the others hold their loaded value.
- **Frame end.** out_last = (bit_idx == 2^N−2). A beat with out_last set moves the block to IDLE and sets done on the next cycle.
- **LFSR step.** Fibonacci structure: shift left, feedback enters bit 0. Feedback is the XOR of the following bits:
  - N=3: bits 2, 1
  - N=4: bits 3, 2
  - N=5: bits 4, 2
  - N=6: bits 5, 4
  - N=7: bits 6, 5
  - N=8: bits 7, 5, 4, 3
  - N=10: bits 9, 6
  - N=12: bits 11, 5, 3, 0
  - N=16: bits 15, 13, 12, 10
- **abort in RUN.** Return to IDLE next cycle. No done pulse, and the in-flight beat is not counted.
- **start while not in IDLE.** Ignored.
- **Held beats.** While out_ready = 0, x_out, bit_idx and all LFSRs hold their values.
- **Outputs in IDLE.** out_valid, out_last and x_out are 0. bit_idx and LFSRs hold their last values.

## Timing
- **Reset values.** State IDLE. busy, out_valid, out_last, done and x_out are 0. bit_idx is 0. Every LFSR is all-ones.
- **Reset mid-frame.** Same as above, applied on the next clock edge. No done pulse.
- **Start latency.** start sampled at edge T gives RUN from T. The first beat is valid in the cycle after T, with LFSR = seed.
- **Frame length.** With out_ready held high, a frame is exactly 2^N−1 cycles of out_valid.
- **done timing.** done is high in the cycle after the last beat, while the block is already in IDLE. A start sampled in that same cycle is accepted.
- **Output paths.** All outputs are registered or decoded from registers only. There is no combinational path from out_ready to out_valid.

## Structure
- Package sc_lfsr_pkg holds:
  - function lfsr_tap_mask(int n) returning an N-bit tap mask;
  - a constant listing the supported widths;
  - the state enum {IDLE, RUN}.
- Sub-module sc_lfsr_core (parameter N), instantiated CH times:
  - ports: load, load_val, step, state;
  - implements zero-seed substitution and the tap mask.
- The top level holds the FSM, bit counter, latched k/mode, and per-channel comparators.

## Test plan
- **Independent mode, full ready.** N=7, CH=4, k={0,1,64,127}, seeds={1,2,3,4}, corr_mode=0, out_ready=1.
  - Exactly 127 beats.
  - Ones counts 0, 1, 64, 127.
  - out_last only on bit_idx=126; done one cycle later.
- **Correlated mode.** k={10,40,80,127}, corr_mode=1.
  - On every beat, x_out[0] ⇒ x_out[1] ⇒ x_out[2] ⇒ x_out[3].
  - Ones counts 10, 40, 80, 127.
- **Backpressure.** out_ready random at 50%.
  - x_out, bit_idx and lfsr_val are stable across stalls.
  - Exactly 127 handshakes; counts match the full-ready run.
- **Zero seed and period.** seed=0 on all channels, k=127.
  - lfsr_val starts at 0x7F.
  - No value repeats within the frame and 0 is never reached.
  - N=3 variant: 7 beats, counts equal k.
- **Abort and restart.** abort at bit_idx=50, then start in the same cycle abort is seen.
  - IDLE for one cycle, no done pulse, start ignored.
  - A fresh start runs a full 127-beat frame.
- **Reset mid-frame, then back-to-back.** rst_n low at bit_idx=30.
  - All outputs take their reset values.
  - A start asserted in the cycle done is high is accepted, giving a back-to-back frame.
